sample_reader: RTL

Reads one completed capture out of the sample memory and streams it as bytes over a valid/ready interface, oldest sample first. It is the read-side counterpart of the sampler. It sits between the sample RAM's read port and the host-link byte transmitter, and is started by the control FSM once the sampler reports done. It undoes the circular-buffer rotation: the byte stream always begins with the oldest pre-trigger sample, wherever the write pointer wrapped.

---
 rtl/oscilo_pkg.sv | 29 ++
 rtl/sample_reader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/oscilo_pkg.sv
// Shared oscilloscope package: reader state encoding, header sync byte, capture depth default.
// The header constant and HDR states exist only when SAMPLE_READER_HEADER_EN is defined.
package oscilo_pkg;

    localparam int unsigned SAMPLE_DEPTH_DEF = 8;

`ifdef SAMPLE_READER_HEADER_EN
    localparam logic [7:0] HDR_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_FETCH = 3'd3,
        ST_WAIT  = 3'd4,
        ST_SEND  = 3'd5,
        ST_DONE  = 3'd6
    } reader_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd3,
        ST_WAIT  = 3'd4,
        ST_SEND  = 3'd5,
        ST_DONE  = 3'd6
    } reader_state_t;
`endif

endpackage

// File: rtl/sample_reader.sv
// Streams one capture from sample RAM as bytes, oldest sample first (undoes ring rotation).
// Optional SAMPLE_READER_HEADER_EN prefixes the stream with 0xA5 and the latched offset byte.
module sample_reader
    import oscilo_pkg::*;
#(
    parameter int unsigned SAMPLE_DEPTH = SAMPLE_DEPTH_DEF
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SAMPLE_DEPTH-1:0] offset,
    output logic                    busy,
    output logic                    done,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    output logic                    mem_re,
    input  logic [7:0]              mem_rdata,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);

    localparam int unsigned AW   = SAMPLE_DEPTH;
    localparam int unsigned CW   = SAMPLE_DEPTH + 1;
    localparam int unsigned N    = 1 << SAMPLE_DEPTH;
    localparam int unsigned HALF = 1 << (SAMPLE_DEPTH - 1);

    reader_state_t   r_state;
    logic [AW-1:0]   r_addr;
    logic [CW-1:0]   r_count;
    logic            r_busy;
    logic            r_done;
    logic            r_mem_re;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
`ifdef SAMPLE_READER_HEADER_EN
    logic [AW-1:0]   r_offset;
`endif

    logic            w_handshake;
    logic            w_last;
    logic [AW-1:0]   w_base;

    assign w_handshake = r_tx_valid && tx_ready;
    assign w_last      = (r_count == CW'(N - 1));
    // Oldest pre-trigger sample sits HALF entries behind the trigger write address.
    assign w_base      = offset - AW'(HALF);

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_re   <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
`ifdef SAMPLE_READER_HEADER_EN
            r_offset   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= w_base;
                        r_count <= '0;
                        r_busy  <= 1'b1;
`ifdef SAMPLE_READER_HEADER_EN
                        r_offset   <= offset;
                        r_tx_data  <= HDR_SYNC;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_HDR0;
`else
                        r_mem_re <= 1'b1;
                        r_state  <= ST_FETCH;
`endif
                    end
                end
`ifdef SAMPLE_READER_HEADER_EN
                ST_HDR0: begin
                    if (w_handshake) begin
                        r_tx_data <= 8'(r_offset);
                        r_state   <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (w_handshake) begin
                        r_tx_valid <= 1'b0;
                        r_mem_re   <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
`endif
                ST_FETCH: begin
                    r_mem_re <= 1'b0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_tx_data  <= mem_rdata;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    // Data and valid hold until the transmitter takes the byte.
                    if (w_handshake) begin
                        r_tx_valid <= 1'b0;
                        r_addr     <= r_addr + AW'(1);
                        r_count    <= r_count + CW'(1);
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_mem_re <= 1'b1;
                            r_state  <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_addr = r_addr;
    assign mem_re   = r_mem_re;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule
